// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - bus widths and field layouts for the memory stage.
// Defining MS_FWD_EN widens the forward/block bus to carry write data to decode.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 71;
  localparam int MS_TO_WS_BUS_WD = 70;
`ifdef MS_FWD_EN
  localparam int MS_FWD_BLK_BUS_WD = 38;
`else
  localparam int MS_FWD_BLK_BUS_WD = 6;
`endif

  typedef struct packed {
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_to_ms_t;

  typedef struct packed {
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_t;

endpackage

// File: rtl/ms_rdata_hold.sv
// rtl/ms_rdata_hold.sv - captures SRAM load data on the first stall cycle so the
// result stays stable while write-back is busy and execute moves the address.
module ms_rdata_hold (
  input  logic        clk,
  input  logic        resetn,
  input  logic        first,
  input  logic        stall,
  input  logic        clear,
  input  logic [31:0] rdata,
  output logic [31:0] hold,
  output logic        hold_v
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold   <= 32'h0;
      hold_v <= 1'b0;
    end else if (clear) begin
      hold_v <= 1'b0;
    end else if (first && stall) begin
      hold   <= rdata;
      hold_v <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory-access stage: execute handoff, load data select,
// write-back handoff and forward/block bus (write data included under MS_FWD_EN).
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         ws_allowin,
  output logic                         ms_allowin,
  input  logic                         es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0]   es_to_ms_bus,
  input  logic [31:0]                  data_sram_rdata,
  output logic                         ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0]   ms_to_ws_bus,
  output logic [MS_FWD_BLK_BUS_WD-1:0] ms_fwd_blk_bus
);

  logic        ms_valid;
  logic        ms_ready_go;
  es_to_ms_t   bus_r;
  logic [31:0] rdata_hold;
  logic        rdata_hold_v;
  logic        accept;
  logic        drain;
  logic [31:0] mem_result;
  logic [31:0] final_result;
  logic        rf_wen;
  ms_to_ws_t   ws_bus;

  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign accept         = es_to_ms_valid && ms_allowin;
  assign drain          = ms_valid && ws_allowin && !es_to_ms_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_r <= '0;
    end else if (accept) begin
      bus_r <= es_to_ms_t'(es_to_ms_bus);
    end
  end

  // Only the first occupancy cycle sees valid SRAM data; once the flag is set, later
  // stall cycles must not overwrite it.
  ms_rdata_hold u_rdata_hold (
    .clk    (clk),
    .resetn (resetn),
    .first  (ms_valid && !rdata_hold_v),
    .stall  (!ws_allowin),
    .clear  (accept || drain),
    .rdata  (data_sram_rdata),
    .hold   (rdata_hold),
    .hold_v (rdata_hold_v)
  );

  assign mem_result   = rdata_hold_v ? rdata_hold : data_sram_rdata;
  assign final_result = bus_r.res_from_mem ? mem_result : bus_r.alu_result;
  assign rf_wen       = ms_valid && bus_r.gr_we;

  assign ws_bus.gr_we        = bus_r.gr_we;
  assign ws_bus.dest         = bus_r.dest;
  assign ws_bus.final_result = final_result;
  assign ws_bus.pc           = bus_r.pc;
  assign ms_to_ws_bus        = ws_bus;

`ifdef MS_FWD_EN
  assign ms_fwd_blk_bus = {rf_wen, bus_r.dest, final_result};
`else
  assign ms_fwd_blk_bus = {rf_wen, bus_r.dest};
`endif

endmodule
